// File: rtl/washer_pkg.sv
// Shared types and phase-duration lookup for the washing-machine sequencer.
// The door-lock option (WASHER_DOOR_LOCK_EN) needs nothing from this package.
package washer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOAK,
      S_WASH,
      S_DRAIN,
      S_RINSE,
      S_SPIN
   } state_t;

   localparam logic LOAD_LO = 1'b0;
   localparam logic LOAD_HI = 1'b1;

   // Length in cycles of the phase being entered; IDLE has no length.
   function automatic int unsigned phase_dur(
      input state_t      st,
      input logic        load,
      input int unsigned soak_lo,
      input int unsigned soak_hi,
      input int unsigned wash_lo,
      input int unsigned wash_hi,
      input int unsigned rinse,
      input int unsigned drain,
      input int unsigned spin
   );
      int unsigned d;
      d = 0;
      case (st)
         S_SOAK:  d = (load == LOAD_HI) ? soak_hi : soak_lo;
         S_WASH:  d = (load == LOAD_HI) ? wash_hi : wash_lo;
         S_DRAIN: d = drain;
         S_RINSE: d = rinse;
         S_SPIN:  d = spin;
         default: d = 0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/washing_machine_ctrl_phase_timer.sv
// Per-phase down counter: loaded on phase entry, frozen by hold, stops at zero.
module phase_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hold,
   output logic             zero,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (!hold && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/washing_machine_ctrl.sv
// Washing-machine phase sequencer with internal phase timers, rinse repeats,
// pause and abort-via-drain. Optional door interlock under WASHER_DOOR_LOCK_EN.
module washing_machine_ctrl
   import washer_pkg::*;
#(
   parameter int          CNT_W     = 16,
   parameter int unsigned T_SOAK_LO = 4,
   parameter int unsigned T_SOAK_HI = 6,
   parameter int unsigned T_WASH_LO = 5,
   parameter int unsigned T_WASH_HI = 8,
   parameter int unsigned T_RINSE   = 3,
   parameter int unsigned T_DRAIN   = 2,
   parameter int unsigned T_SPIN    = 4,
   parameter int unsigned N_RINSE   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         select,
   input  logic                         stop,
   input  logic                         pause,
`ifdef WASHER_DOOR_LOCK_EN
   input  logic                         door_closed,
   output logic                         door_lock,
`endif
   output logic                         idle,
   output logic                         soak_low,
   output logic                         soak_high,
   output logic                         wash_low,
   output logic                         wash_high,
   output logic                         rinse,
   output logic                         spin,
   output logic                         drain,
   output logic                         busy,
   output logic                         paused,
   output logic                         done,
   output logic                         aborted,
   output logic [$clog2(N_RINSE+1)-1:0] rinse_idx,
   output logic [CNT_W-1:0]             time_left
);

   localparam int RI_W = $clog2(N_RINSE + 1);

   state_t           state, state_nx;
   logic             load_lvl, lvl_eff;
   logic             abort_q;
   logic             active, start_ok, stop_act, hold_req, hold;
   logic             tmr_load, tmr_zero;
   logic [CNT_W-1:0] tmr_val, tmr_count;
   int unsigned      dur;

   assign active = (state != S_IDLE);
`ifdef WASHER_DOOR_LOCK_EN
   assign start_ok  = (state == S_IDLE) && start && door_closed;
   assign hold_req  = pause || !door_closed;
   assign door_lock = active;
`else
   assign start_ok  = (state == S_IDLE) && start;
   assign hold_req  = pause;
`endif
   // Stop outranks a hold so an abort while paused acts at once.
   assign stop_act = active && stop;
   assign hold     = active && hold_req && !stop_act;
   assign lvl_eff  = (state == S_IDLE) ? select : load_lvl;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start_ok) state_nx = S_SOAK;
         S_SOAK:  if (stop_act) state_nx = S_DRAIN;
                  else if (!hold && tmr_zero) state_nx = S_WASH;
         S_WASH:  if (stop_act || (!hold && tmr_zero)) state_nx = S_DRAIN;
         S_RINSE: if (stop_act || (!hold && tmr_zero)) state_nx = S_DRAIN;
         S_SPIN:  if (stop_act) state_nx = S_DRAIN;
                  else if (!hold && tmr_zero) state_nx = S_IDLE;
         S_DRAIN: if (!hold && tmr_zero) begin
                     if (abort_q || stop_act)                state_nx = S_IDLE;
                     else if (rinse_idx == RI_W'(N_RINSE))  state_nx = S_SPIN;
                     else                                    state_nx = S_RINSE;
                  end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      tmr_load = (state_nx != state);
      dur      = phase_dur(state_nx, lvl_eff, T_SOAK_LO, T_SOAK_HI, T_WASH_LO,
                           T_WASH_HI, T_RINSE, T_DRAIN, T_SPIN);
      tmr_val  = (dur == 0) ? '0 : CNT_W'(dur - 1);
   end

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .hold     (hold),
      .zero     (tmr_zero),
      .count    (tmr_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         load_lvl  <= LOAD_LO;
         abort_q   <= 1'b0;
         rinse_idx <= '0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         state <= state_nx;
         if (start_ok) load_lvl <= select;
         if (state_nx == S_IDLE) abort_q <= 1'b0;
         else if (stop_act)      abort_q <= 1'b1;
         // Cleared on the way into IDLE so it reads 0 throughout IDLE.
         if (state_nx == S_IDLE)
            rinse_idx <= '0;
         else if ((state == S_RINSE) && (state_nx == S_DRAIN))
            rinse_idx <= rinse_idx + RI_W'(1);
         done    <= (state == S_SPIN)  && (state_nx == S_IDLE);
         aborted <= (state == S_DRAIN) && (state_nx == S_IDLE);
      end
   end

   assign idle      = (state == S_IDLE);
   assign soak_low  = (state == S_SOAK) && (load_lvl == LOAD_LO);
   assign soak_high = (state == S_SOAK) && (load_lvl == LOAD_HI);
   assign wash_low  = (state == S_WASH) && (load_lvl == LOAD_LO);
   assign wash_high = (state == S_WASH) && (load_lvl == LOAD_HI);
   assign rinse     = (state == S_RINSE);
   assign spin      = (state == S_SPIN);
   assign drain     = (state == S_DRAIN);
   assign busy      = active;
   assign paused    = hold;
   assign time_left = tmr_count;

endmodule
